// File: rtl/regfile_write_arbiter.sv
// Write-port arbiter for the 8x8 register file.
// Clears every register to INIT_VAL after reset, then shares the single registered
// write port between ALU writeback (port 0) and load writeback (port 1) round-robin.
module regfile_write_arbiter #(
    parameter int unsigned   DW       = 8,
    parameter int unsigned   AW       = 3,
    parameter int unsigned   NREG     = 8,
    parameter bit            R0_PROT  = 1'b1,
    parameter logic [DW-1:0] INIT_VAL = '0
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          req0,
    input  logic [AW-1:0] addr0,
    input  logic [DW-1:0] data0,
    output logic          gnt0,
    input  logic          req1,
    input  logic [AW-1:0] addr1,
    input  logic [DW-1:0] data1,
    output logic          gnt1,
    output logic          regwrite,
    output logic [AW-1:0] wa,
    output logic [DW-1:0] wd,
    output logic          busy
);

    typedef enum logic {StInit, StRun} state_e;

    localparam logic [AW-1:0] LastAddr = AW'(NREG - 1);

    state_e        state_q, state_d;
    logic [AW-1:0] cnt_q, cnt_d;
    logic          last_q, last_d;      // port that won most recently; 1 so port 0 wins first
    logic          regwrite_q, regwrite_d;
    logic [AW-1:0] wa_q, wa_d;
    logic [DW-1:0] wd_q, wd_d;

    assign busy     = (state_q == StInit);
    assign gnt0     = !busy && req0 && (!req1 || last_q);
    assign gnt1     = !busy && req1 && (!req0 || !last_q);
    assign regwrite = regwrite_q;
    assign wa       = wa_q;
    assign wd       = wd_q;

    // Next-state: INIT sweeps the address space, RUN forwards the granted request.
    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        last_d     = last_q;
        regwrite_d = 1'b0;
        wa_d       = wa_q;
        wd_d       = wd_q;
        case (state_q)
            StInit: begin
                // r0 is cleared here regardless of R0_PROT
                regwrite_d = 1'b1;
                wa_d       = cnt_q;
                wd_d       = INIT_VAL;
                cnt_d      = cnt_q + AW'(1);
                if (cnt_q == LastAddr) begin
                    state_d = StRun;
                    cnt_d   = '0;
                end
            end
            StRun: begin
                if (gnt0) begin
                    regwrite_d = !(R0_PROT && (addr0 == '0));
                    wa_d       = addr0;
                    wd_d       = data0;
                    last_d     = 1'b0;
                end else if (gnt1) begin
                    regwrite_d = !(R0_PROT && (addr1 == '0));
                    wa_d       = addr1;
                    wd_d       = data1;
                    last_d     = 1'b1;
                end
            end
            default: begin
                state_d = StInit;
                cnt_d   = '0;
            end
        endcase
    end

    // State and registered write-port outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= StInit;
            cnt_q      <= '0;
            last_q     <= 1'b1;
            regwrite_q <= 1'b0;
            wa_q       <= '0;
            wd_q       <= '0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            last_q     <= last_d;
            regwrite_q <= regwrite_d;
            wa_q       <= wa_d;
            wd_q       <= wd_d;
        end
    end

endmodule
